// File: rtl/ball_motion_ctrl.sv
// Ball position sequencer for the 640x480 renderer: steps the ball once per frame,
// reflects it off the screen edges, and reports bounces to the score/sound logic.
module ball_motion_ctrl #(
   parameter int BALL_RADIUS = 8,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int X_INIT      = 320,
   parameter int Y_INIT      = 240,
   parameter int SPEED       = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       launch,
   input  logic       pause,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic       dir_x,
   output logic       dir_y,
   output logic       moving,
   output logic       bounce,
   output logic [7:0] bounce_count
);

   localparam logic [10:0] XMIN = 11'(BALL_RADIUS);
   localparam logic [10:0] XMAX = 11'(H_ACTIVE - 1 - BALL_RADIUS);
   localparam logic [10:0] YMIN = 11'(BALL_RADIUS);
   localparam logic [10:0] YMAX = 11'(V_ACTIVE - 1 - BALL_RADIUS);
   localparam logic [10:0] SPD  = 11'(SPEED);

   typedef enum logic [1:0] {IDLE, MOVE, PAUSED} state_t;

   typedef struct packed {
      logic [9:0] pos;
      logic       dir;
      logic       hit;
   } axisStep_t;

   state_t    state, nextState;
   logic      doUpdate;
   axisStep_t stepX, stepY;
   logic      edgeHit;

   // One axis advance; the 11-bit compare keeps pos+SPEED from wrapping near the limits.
   function automatic axisStep_t stepAxis(input logic [9:0] pos, input logic dir,
                                          input logic [10:0] lo, input logic [10:0] hi);
      logic [10:0] wide;
      axisStep_t   r;
      wide = {1'b0, pos};
      r    = '{pos: pos, dir: dir, hit: 1'b0};
      if (dir) begin
         if (wide + SPD >= hi) r = '{pos: hi[9:0], dir: 1'b0, hit: 1'b1};
         else                  r.pos = 10'(wide + SPD);
      end else begin
         if (wide <= lo + SPD) r = '{pos: lo[9:0], dir: 1'b1, hit: 1'b1};
         else                  r.pos = 10'(wide - SPD);
      end
      return r;
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      nextState = state;
      doUpdate  = 1'b0;
      case (state)
         IDLE:    if (launch) nextState = MOVE;
         MOVE: begin
            if (pause)           nextState = PAUSED;
            else if (frame_tick) doUpdate  = 1'b1;
         end
         PAUSED:  if (!pause) nextState = MOVE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      stepX   = stepAxis(x_pos, dir_x, XMIN, XMAX);
      stepY   = stepAxis(y_pos, dir_y, YMIN, YMAX);
      edgeHit = stepX.hit | stepY.hit;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         x_pos        <= 10'(X_INIT);
         y_pos        <= 10'(Y_INIT);
         dir_x        <= 1'b1;
         dir_y        <= 1'b1;
         bounce       <= 1'b0;
         bounce_count <= 8'd0;
      end else begin
         state  <= nextState;
         bounce <= doUpdate & edgeHit;
         if (doUpdate) begin
            x_pos <= stepX.pos;
            dir_x <= stepX.dir;
            y_pos <= stepY.pos;
            dir_y <= stepY.dir;
         end
         // A corner hit counts once: both axes feed the single edgeHit term.
         if (state == IDLE && launch)
            bounce_count <= 8'd0;
         else if (doUpdate && edgeHit && bounce_count != 8'hFF)
            bounce_count <= bounce_count + 8'd1;
      end
   end

   assign moving = (state == MOVE);

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomized self-checking bench for ball_motion_ctrl against a behavioural model
// built directly from the motion rules (modes, per-axis reflect, saturating count).
module tb_ball_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst, frame_tick, launch, pause;
   logic [9:0] x_pos, y_pos;
   logic       dir_x, dir_y, moving, bounce;
   logic [7:0] bounce_count;

   int checks = 0;
   int errors = 0;

   // Reference model state: mode 0 = idle, 1 = moving, 2 = paused.
   int mMode, mX, mY, mDx, mDy, mBounce, mCount;

   localparam int R = 8, SP = 2;
   localparam int XLO = R, XHI = 640 - 1 - R, YLO = R, YHI = 480 - 1 - R;

   ball_motion_ctrl dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch), .pause(pause),
      .x_pos(x_pos), .y_pos(y_pos), .dir_x(dir_x), .dir_y(dir_y),
      .moving(moving), .bounce(bounce), .bounce_count(bounce_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
      end
   endtask

   function automatic void moveAxis(inout int pos, inout int dir, input int lo, input int hi,
                                    output bit hit);
      hit = 0;
      if (dir == 1) begin
         if (pos + SP >= hi) begin pos = hi; dir = 0; hit = 1; end
         else pos = pos + SP;
      end else begin
         if (pos <= lo + SP) begin pos = lo; dir = 1; hit = 1; end
         else pos = pos - SP;
      end
   endfunction

   function automatic void modelStep(input bit r, input bit t, input bit l, input bit p);
      bit hx, hy;
      mBounce = 0;
      if (r) begin
         mMode = 0; mX = 320; mY = 240; mDx = 1; mDy = 1; mCount = 0;
         return;
      end
      case (mMode)
         0: if (l) begin mMode = 1; mCount = 0; end
         1: begin
            if (p) mMode = 2;
            else if (t) begin
               moveAxis(mX, mDx, XLO, XHI, hx);
               moveAxis(mY, mDy, YLO, YHI, hy);
               if (hx || hy) begin
                  mBounce = 1;
                  if (mCount < 255) mCount++;
               end
            end
         end
         default: if (!p) mMode = 1;
      endcase
   endfunction

   task automatic compareAll(input string tag);
      check({tag, ".x"},      int'(x_pos),        mX);
      check({tag, ".y"},      int'(y_pos),        mY);
      check({tag, ".dx"},     int'(dir_x),        mDx);
      check({tag, ".dy"},     int'(dir_y),        mDy);
      check({tag, ".moving"}, int'(moving),       (mMode == 1) ? 1 : 0);
      check({tag, ".bounce"}, int'(bounce),       mBounce);
      check({tag, ".count"},  int'(bounce_count), mCount);
   endtask

   // One clock: drive at negedge, advance the model with the edge, sample 1 time unit later.
   task automatic cycle(input string tag, input bit r, input bit t, input bit l, input bit p);
      @(negedge clk);
      rst = r; frame_tick = t; launch = l; pause = p;
      @(posedge clk);
      #1;
      modelStep(r, t, l, p);
      compareAll(tag);
   endtask

   initial begin
      bit sawYBounce;
      rst = 1'b1; frame_tick = 1'b0; launch = 1'b0; pause = 1'b0;

      // Reset state, with inputs that reset must override.
      cycle("reset", 1, 1, 1, 0);
      cycle("reset", 1, 0, 0, 1);
      check("reset_x", int'(x_pos), 320);
      check("reset_y", int'(y_pos), 240);

      // Idle holds; launch with a coincident frame_tick does not move the ball.
      cycle("idle", 0, 1, 0, 0);
      cycle("launch", 0, 1, 1, 0);
      check("launch_x", int'(x_pos), 320);
      for (int i = 0; i < 3; i++) begin
         cycle("tick", 0, 1, 0, 0);
         cycle("gap", 0, 0, 0, 0);
      end
      check("three_ticks_x", int'(x_pos), 326);
      check("three_ticks_y", int'(y_pos), 246);

      // Run to the bottom edge and one tick past it.
      sawYBounce = 0;
      for (int i = 0; i < 300 && !sawYBounce && errors < 20; i++) begin
         cycle("run_down", 0, 1, 0, 0);
         if (mBounce == 1) begin
            sawYBounce = 1;
            check("bottom_y", int'(y_pos), 471);
            check("bottom_dy", int'(dir_y), 0);
            check("bottom_count", int'(bounce_count), 1);
         end
      end
      check("bottom_reached", int'(sawYBounce), 1);
      cycle("after_bottom", 0, 1, 0, 0);
      check("after_bottom_y", int'(y_pos), 469);
      cycle("bounce_clear", 0, 0, 0, 0);

      // Pause wins over a coincident tick; ticks ignored while paused.
      cycle("pause_tick", 0, 1, 0, 1);
      check("paused_moving", int'(moving), 0);
      for (int i = 0; i < 4; i++) cycle("paused", 0, i[0], i[1], 1);
      cycle("resume", 0, 0, 0, 0);
      cycle("resume_tick", 0, 1, 0, 0);

      // Randomized traffic over all controls.
      for (int i = 0; i < 6000 && errors < 20; i++)
         cycle("random", ($urandom_range(599) == 0), ($urandom_range(1) == 0),
               ($urandom_range(7) == 0), ($urandom_range(9) == 0));

      // Reset mid-motion coincident with a frame tick.
      cycle("pre_rst", 0, 0, 1, 0);
      for (int i = 0; i < 20; i++) cycle("pre_rst_run", 0, 1, 0, 0);
      cycle("rst_tick", 1, 1, 0, 0);
      check("rst_tick_x", int'(x_pos), 320);
      check("rst_tick_count", int'(bounce_count), 0);

      // Soak: continuous ticks until well beyond 255 bounces.
      cycle("soak_launch", 0, 0, 1, 0);
      for (int i = 0; i < 50000 && errors < 20; i++) cycle("soak", 0, 1, 0, 0);
      check("soak_saturated", int'(bounce_count), 255);
      cycle("soak_hold", 0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
